// File: rtl/rect_fetch_if.sv
// -----------------------------------------------------------------------------
// rect_fetch_if
// Bundles the three handshakes around the rectangle fetcher:
//   cmd_*  : feature-index request (valid/ready, index held until accepted)
//   rom_*  : synchronous ROM read port (en/addr out, data back one cycle later)
//   out_*  : packed rectangle to the feature-evaluation datapath (valid/ready)
// Modports:
//   master : the fetcher itself (drives cmd_ready, rom_en/addr, rectangle)
//   slave  : its environment (requester, ROM and consumer)
// -----------------------------------------------------------------------------
interface rect_fetch_if #(
    parameter int W_DATA = 5,
    parameter int W_ADDR = 14,
    parameter int W_IDX  = 12
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [W_IDX-1:0]  cmd_idx;

    logic              rom_en;
    logic [W_ADDR-1:0] rom_addr;
    logic [W_DATA-1:0] rom_data;

    logic              out_valid;
    logic              out_ready;
    logic [W_DATA-1:0] rect_x;
    logic [W_DATA-1:0] rect_y;
    logic [W_DATA-1:0] rect_w;
    logic [W_DATA-1:0] rect_h;
    logic              rect_empty;

    modport master (
        input  cmd_valid, cmd_idx, rom_data, out_ready,
        output cmd_ready, rom_en, rom_addr, out_valid,
               rect_x, rect_y, rect_w, rect_h, rect_empty
    );

    modport slave (
        output cmd_valid, cmd_idx, rom_data, out_ready,
        input  cmd_ready, rom_en, rom_addr, out_valid,
               rect_x, rect_y, rect_w, rect_h, rect_empty
    );
endinterface

// File: rtl/rect_fetch.sv
// -----------------------------------------------------------------------------
// rect_fetch
// Reader side of the rectangle-parameter ROM of the cascade classifier.
// Accepts one feature index at a time, reads its four words (x, y, w, h) from
// a ROM with one cycle of read latency, and presents them as one rectangle on
// a valid/ready output that holds under backpressure.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : rect_fetch_if.master (cmd_*, rom_*, out_*/rect_* signals)
// Timing (accept at cycle T): ROM reads issued T+1..T+4, rectangle valid
// from T+6, next command acceptable the cycle after the output handshake.
// -----------------------------------------------------------------------------
module rect_fetch #(
    parameter int W_DATA = 5,
    parameter int W_ADDR = 14,
    parameter int W_IDX  = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    rect_fetch_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic              run_q;
    logic [1:0]        k_q, k_d;
    logic              rom_en_q, rom_en_d;
    logic [W_ADDR-1:0] rom_addr_q, rom_addr_d;
    logic [W_DATA-1:0] x_q, x_d;
    logic [W_DATA-1:0] y_q, y_d;
    logic [W_DATA-1:0] w_q, w_d;
    logic [W_DATA-1:0] h_q, h_d;
    logic              empty_q, empty_d;
    logic              cmd_ready;

    // run_q keeps cmd_ready low while reset is held even though the state
    // register already sits in IDLE; it rises on the first edge after release.
    assign cmd_ready = (state_q == IDLE) && run_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            run_q      <= 1'b0;
            k_q        <= '0;
            rom_en_q   <= 1'b0;
            rom_addr_q <= '0;
            x_q        <= '0;
            y_q        <= '0;
            w_q        <= '0;
            h_q        <= '0;
            empty_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_q      <= 1'b1;
            k_q        <= k_d;
            rom_en_q   <= rom_en_d;
            rom_addr_q <= rom_addr_d;
            x_q        <= x_d;
            y_q        <= y_d;
            w_q        <= w_d;
            h_q        <= h_d;
            empty_q    <= empty_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        rom_en_d   = rom_en_q;
        rom_addr_d = rom_addr_q;
        x_d        = x_q;
        y_d        = y_q;
        w_d        = w_q;
        h_d        = h_q;
        empty_d    = empty_q;

        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid && cmd_ready) begin
                    state_d    = ISSUE;
                    k_d        = '0;
                    rom_en_d   = 1'b1;
                    rom_addr_d = {W_IDX'(bus.cmd_idx), 2'b00};
                end
            end

            ISSUE: begin
                // rom_data in this cycle answers the read issued one cycle
                // earlier, i.e. word k_q-1; k_q==0 has nothing returning yet.
                unique case (k_q)
                    2'd1:    x_d = bus.rom_data;
                    2'd2:    y_d = bus.rom_data;
                    2'd3:    w_d = bus.rom_data;
                    default: ;
                endcase

                if (k_q == 2'd3) begin
                    state_d  = DRAIN;
                    k_d      = '0;
                    rom_en_d = 1'b0;
                end else begin
                    k_d        = k_q + 2'd1;
                    rom_addr_d = rom_addr_q + W_ADDR'(1);
                end
            end

            DRAIN: begin
                // h arrives now; empty uses it directly so the flag is
                // registered together with the field it depends on.
                h_d     = bus.rom_data;
                empty_d = (w_q == '0) || (bus.rom_data == '0);
                state_d = HOLD;
            end

            HOLD: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign bus.cmd_ready  = cmd_ready;
    assign bus.rom_en     = rom_en_q;
    assign bus.rom_addr   = rom_addr_q;
    assign bus.out_valid  = (state_q == HOLD);
    assign bus.rect_x     = x_q;
    assign bus.rect_y     = y_q;
    assign bus.rect_w     = w_q;
    assign bus.rect_h     = h_q;
    assign bus.rect_empty = empty_q;

endmodule

// File: doc/rect_fetch.md
Name: rect_fetch

Overview:
- Reader side of the rectangle-parameter ROM port of the cascade classifier.
- Accepts a feature index and issues four consecutive synchronous ROM reads (en/addr, 1-cycle read latency). Captures the returned 5-bit x, y, w, h fields.
- Presents them as one packed rectangle on a valid/ready output to the feature-evaluation datapath.
- One command is in flight at a time; the output register holds the rectangle under backpressure.

Parameters:
- W_DATA, 5: width of each ROM word and of each rect field.
- W_ADDR, 14: ROM address width.
- W_IDX, 12: feature index width; must equal W_ADDR-2.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  feature index request valid.
- cmd_ready  out  1  block can accept a request.
- cmd_idx  in  W_IDX  feature index.
- rom_en  out  1  ROM read enable.
- rom_addr  out  W_ADDR  ROM read address.
- rom_data  in  W_DATA  ROM read data; valid the cycle after rom_en=1.
- out_valid  out  1  rectangle valid.
- out_ready  in  1  consumer accepts rectangle.
- rect_x  out  W_DATA  word 0.
- rect_y  out  W_DATA  word 1.
- rect_w  out  W_DATA  word 2.
- rect_h  out  W_DATA  word 3.
- rect_empty  out  1  high when rect_w==0 or rect_h==0 (unused rect slot).

Behaviour:
- Reset (rst=0, async) values:
  - state=IDLE, cmd_ready=0 while in reset.
  - rom_en=0, rom_addr=0, out_valid=0.
  - rect_x/y/w/h=0, rect_empty=0.
  - Internal word counter = 0.
- cmd_ready = (state==IDLE), registered-state decode. cmd_ready is 1 from the first cycle after reset deassertion.
- Memory layout, fixed: word address = {cmd_idx, 2'b00} + k, k=0..3. Word order is k=0 x, k=1 y, k=2 w, k=3 h. No wrap beyond the index range: the base of the last index is 0x3FFC and +3 stays in range.
- States: IDLE, ISSUE, DRAIN, HOLD.
- IDLE:
  - On cmd_valid&&cmd_ready at cycle T, register base={cmd_idx,2'b00} and go to ISSUE.
  - out_valid=0.
- ISSUE (cycles T+1..T+4):
  - rom_en=1 and rom_addr=base+k, k incrementing 0..3 one per cycle (registered outputs).
  - Data for word k is captured at the end of the cycle following its issue: x at end of T+2, y at T+3, w at T+4.
  - After k=3 is issued, go to DRAIN.
- DRAIN (cycle T+5):
  - rom_en=0. rom_addr holds the last value.
  - Capture h at the end of T+5 and go to HOLD.
- HOLD (from T+6):
  - out_valid=1. rect_x/y/w/h and rect_empty are stable while out_valid && !out_ready.
  - On out_ready=1: the handshake completes, out_valid=0 next cycle, and state goes to IDLE.
  - The next command is acceptable in the first cycle after the handshake.
- Latency: command accept cycle T to out_valid=1 is 6 cycles. Maximum throughput is one rectangle per 7 cycles with out_ready held at 1.
- out_ready=1 in the same cycle out_valid first rises completes the handshake in that cycle.
- out_ready while out_valid=0 is ignored. cmd_valid while cmd_ready=0 is ignored; the requester holds cmd_idx until accepted.
- rect_empty is computed from the captured w/h and registered alongside them. It is valid only with out_valid.
- Reset asserted mid-fetch or in HOLD:
  - All outputs go to reset values immediately.
  - The partial rectangle is discarded and no out_valid pulse follows.
  - After release the block is in IDLE.
- rom_en is 0 in IDLE, DRAIN and HOLD. Exactly 4 rom_en cycles occur per accepted command.

Test Plan:
- Reset release, then cmd_idx=0x023 -> rom_addr 0x08C,0x08D,0x08E,0x08F on consecutive rom_en cycles. out_valid 6 cycles after accept with x=0x0C, y=0x0C, w=0x07, h=0x06, rect_empty=0.
- cmd_idx=0x030 with ROM words 0x05,0x0C,0x07,0x07 at 0x0C0..0x0C3 -> x=5, y=12, w=7, h=7, rect_empty=0.
- cmd_idx=0x000 (all-zero words) -> x=y=w=h=0, rect_empty=1. Also a word set with w=7, h=0 -> rect_empty=1.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> fields stable, cmd_ready=0, rom_en=0 throughout. out_ready=1 -> out_valid drops next cycle and cmd_ready=1.
- Back-to-back: cmd_valid held high with indices 0x023 then 0x030, out_ready=1 constantly -> the second accept happens 7 cycles after the first, and two correct rectangles are delivered 7 cycles apart.
- Reset asserted during the third ISSUE cycle -> rom_en=0, out_valid=0, fields 0 immediately. After release there is no stray out_valid, and a new command for 0x023 returns the correct rectangle.
